// File: rtl/hs_pkg.sv
// hs_pkg: shared definitions for the hs_rx_drain slice.
//   - default data width, statistics counter width and ACK timeout
//   - handshake FSM state encoding (IDLE / ACK / GAP)
package hs_pkg;

  localparam int unsigned HS_WIDTH       = 8;
  localparam int unsigned HS_CNT_WIDTH   = 16;
  localparam int unsigned HS_ACK_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_GAP  = 2'd2
  } hs_state_e;

  // Width of a counter able to hold values 0..max_val.
  function automatic int unsigned hs_cnt_bits(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hs_rx_drain_if.sv
// Bus interfaces used by hs_rx_drain.
//
// hs_rx_if : 4-phase FIFO read handshake.
//   rx_rdy  (FIFO -> drain)  FIFO has a word on rx_data
//   rx_data (FIFO -> drain)  word, valid while rx_rdy=1
//   rx_done (drain -> FIFO)  word-taken acknowledge
//   master = FIFO side, slave = drain side.
//
// hs_stream_if : valid/ready stream towards the downstream consumer.
//   m_valid (source -> sink) word valid
//   m_data  (source -> sink) word
//   m_ready (sink -> source) word accepted
//   master = source (drain), slave = sink.
interface hs_rx_if #(
  parameter int unsigned WIDTH = hs_pkg::HS_WIDTH
) ();
  logic             rx_rdy;
  logic [WIDTH-1:0] rx_data;
  logic             rx_done;

  modport master (output rx_rdy, output rx_data, input  rx_done);
  modport slave  (input  rx_rdy, input  rx_data, output rx_done);
endinterface

interface hs_stream_if #(
  parameter int unsigned WIDTH = hs_pkg::HS_WIDTH
) ();
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (output m_valid, output m_data, input  m_ready);
  modport slave  (input  m_valid, input  m_data, output m_ready);
endinterface

// File: rtl/hs_hold_buf.sv
// hs_hold_buf: 2-entry in-order hold buffer between handshake capture and
// the downstream stream. Output word and valid come straight from registers.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push_i           write push_data_i this cycle
//   push_data_i      word to write
//   pop_i            remove head word (ignored when empty)
//   valid_o          head entry valid
//   data_o           head entry word
//   occupancy_o      number of valid entries (0..2)
module hs_hold_buf #(
  parameter int unsigned WIDTH = hs_pkg::HS_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       occupancy_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             head_vld_q, head_vld_d;
  logic             tail_vld_q, tail_vld_d;
  logic             pop_ok;
  logic             push_ok;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    head_vld_d = head_vld_q;
    tail_vld_d = tail_vld_q;

    pop_ok  = pop_i & head_vld_q;
    // A push into a full buffer is only accepted when the head leaves at
    // the same edge; otherwise it is dropped (the drain never issues one).
    push_ok = push_i & (~tail_vld_q | pop_ok);

    unique case ({push_ok, pop_ok})
      2'b01: begin
        head_d     = tail_q;
        head_vld_d = tail_vld_q;
        tail_vld_d = 1'b0;
      end
      2'b10: begin
        if (!head_vld_q) begin
          head_d     = push_data_i;
          head_vld_d = 1'b1;
        end else begin
          tail_d     = push_data_i;
          tail_vld_d = 1'b1;
        end
      end
      2'b11: begin
        // Occupancy unchanged: shift the tail forward (if any) and refill.
        if (tail_vld_q) begin
          head_d = tail_q;
          tail_d = push_data_i;
        end else begin
          head_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      head_vld_q <= head_vld_d;
      tail_vld_q <= tail_vld_d;
    end
  end

  assign valid_o     = head_vld_q;
  assign data_o      = head_q;
  assign occupancy_o = {1'b0, head_vld_q} + {1'b0, tail_vld_q};

endmodule

// File: rtl/hs_rx_drain.sv
// hs_rx_drain: drains words from a FIFO over a 4-phase rdy/done handshake
// and forwards them on a valid/ready stream through a 2-entry hold buffer.
// Keeps capture statistics and flags a stuck handshake.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   rx            FIFO handshake (rx_rdy, rx_data in; rx_done out)
//   m             downstream stream (m_valid, m_data out; m_ready in)
//   enable        permits new handshakes (an ongoing one always completes)
//   clear_stats   synchronous clear of word_count / checksum / proto_err
//   word_count    words captured since reset/clear (wraps)
//   checksum      XOR of words captured since reset/clear
//   proto_err     sticky: rx_rdy held high too long after rx_done
module hs_rx_drain
  import hs_pkg::*;
#(
  parameter int unsigned WIDTH       = HS_WIDTH,
  parameter int unsigned CNT_WIDTH   = HS_CNT_WIDTH,
  parameter int unsigned ACK_TIMEOUT = HS_ACK_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hs_rx_if.slave               rx,
  hs_stream_if.master          m,
  input  logic                 enable,
  input  logic                 clear_stats,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic [WIDTH-1:0]     checksum,
  output logic                 proto_err
);

  localparam int unsigned TMO_W = hs_cnt_bits(ACK_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(ACK_TIMEOUT);

  hs_state_e            state_q, state_d;
  logic                 done_q, done_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     sum_q, sum_d;
  logic                 err_q, err_d;

  logic                 capture;
  logic                 timeout_hit;
  logic                 buf_valid;
  logic [WIDTH-1:0]     buf_data;
  logic [1:0]           buf_occ;
  logic                 pop;

  assign pop = buf_valid & m.m_ready;

  // Handshake FSM. rx_done is a register set on the capture edge and
  // cleared on the edge that samples rx_rdy low.
  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    tmo_d       = tmo_q;
    capture     = 1'b0;
    timeout_hit = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (rx.rx_rdy && enable && (buf_occ != 2'd2)) begin
          capture = 1'b1;
          done_d  = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!rx.rx_rdy) begin
          done_d  = 1'b0;
          tmo_d   = '0;
          state_d = ST_GAP;
        end else if (tmo_q == TMO_MAX) begin
          // Counter saturates; the FSM keeps waiting for rx_rdy to drop.
          timeout_hit = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_GAP: begin
        done_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        done_d  = 1'b0;
        tmo_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Statistics. clear_stats wins, but a capture at the same edge is still
  // counted so no word goes missing from the new accumulation window.
  always_comb begin
    cnt_d = cnt_q;
    sum_d = sum_q;
    err_d = err_q | timeout_hit;

    if (clear_stats) begin
      cnt_d = capture ? CNT_WIDTH'(1) : '0;
      sum_d = capture ? rx.rx_data : '0;
      err_d = 1'b0;
    end else if (capture) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
      sum_d = sum_q ^ rx.rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      tmo_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  hs_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (capture),
    .push_data_i (rx.rx_data),
    .pop_i       (pop),
    .valid_o     (buf_valid),
    .data_o      (buf_data),
    .occupancy_o (buf_occ)
  );

  assign rx.rx_done = done_q;
  assign m.m_valid  = buf_valid;
  assign m.m_data   = buf_data;
  assign word_count = cnt_q;
  assign checksum   = sum_q;
  assign proto_err  = err_q;

endmodule

// File: tb/tb_hs_rx_drain.sv
module tb_hs_rx_drain;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b1;
  logic          clear_stats = 1'b0;
  logic          m_ready = 1'b0;
  logic          rx_rdy;
  logic [W-1:0]  rx_data;
  logic          rx_done;
  logic [CW-1:0] word_count;
  logic [W-1:0]  checksum;
  logic          proto_err;

  hs_rx_if     #(.WIDTH(W)) rx_if ();
  hs_stream_if #(.WIDTH(W)) m_if ();

  assign rx_if.rx_rdy  = rx_rdy;
  assign rx_if.rx_data = rx_data;
  assign rx_done       = rx_if.rx_done;
  assign m_if.m_ready  = m_ready;

  hs_rx_drain #(
    .WIDTH      (W),
    .CNT_WIDTH  (CW),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx_if),
    .m          (m_if),
    .enable     (enable),
    .clear_stats(clear_stats),
    .word_count (word_count),
    .checksum   (checksum),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         rdy_mode = 1;     // 0: m_ready low, 1: high, 2: random (+ random enable)
  int         mdl_cnt = 0;      // words issued since last clear/reset
  logic [7:0] mdl_sum = '0;     // XOR of words issued since last clear/reset
  int         done_rises = 0;
  bit         chk_gap = 1'b0;
  bit         just_finished = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Downstream ready / enable driver.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = ($urandom_range(0, 2) != 0);
    endcase
    enable = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor: pops the scoreboard on each stream transfer.
  logic [7:0] prev_data;
  logic [7:0] exp_w;
  bit         prev_hold = 1'b0;
  logic       prev_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 32'(m_if.m_valid), 1);
        chk("hold_data", 32'(m_if.m_data), 32'(prev_data));
      end
      if (m_if.m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got 0x%0h expected no word", m_if.m_data);
        end else begin
          exp_w = exp_q.pop_front();
          chk("stream_data", 32'(m_if.m_data), 32'(exp_w));
        end
      end
      prev_hold = m_if.m_valid && !m_ready;
      prev_data = m_if.m_data;
      if (rx_done && !prev_done) done_rises++;
      prev_done = rx_done;
    end
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
    if (k > 0) just_finished = 1'b0;
  endtask

  task automatic clear();
    clear_stats = 1'b1;
    @(posedge clk);
    #1;
    clear_stats = 1'b0;
    mdl_cnt = 0;
    mdl_sum = '0;
    just_finished = 1'b0;
  endtask

  // One complete 4-phase handshake from the FIFO side.
  task automatic send_word(input logic [7:0] w);
    int n;
    exp_q.push_back(w);
    mdl_cnt++;
    mdl_sum ^= w;
    rx_data = w;
    rx_rdy  = 1'b1;
    n = 0;
    while (rx_done !== 1'b1 && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("capture_seen", 32'(rx_done), 1);
    if (chk_gap) chk("capture_latency", n, just_finished ? 2 : 1);
    rx_rdy  = 1'b0;
    rx_data = 8'($urandom);
    n = 0;
    while (rx_done !== 1'b0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ack_release", 32'(rx_done), 0);
    if (chk_gap) chk("ack_len", n, 1);
    just_finished = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    idle(2);
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_count"}, 32'(word_count), mdl_cnt % (1 << CW));
    chk({tag, "_sum"}, 32'(checksum), 32'(mdl_sum));
  endtask

  initial begin
    int n;
    rx_rdy  = 1'b0;
    rx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 32'(rx_done), 0);
    chk("rst_valid", 32'(m_if.m_valid), 0);
    chk("rst_data", 32'(m_if.m_data), 0);
    chk("rst_count", 32'(word_count), 0);
    chk("rst_sum", 32'(checksum), 0);
    chk("rst_err", 32'(proto_err), 0);
    rst_n = 1'b1;
    idle(2);

    // Single word
    chk_gap = 1'b1;
    done_rises = 0;
    send_word(8'hA5);
    idle(3);
    drain();
    chk("single_pulses", done_rises, 1);
    chk("single_count", 32'(word_count), 1);
    chk("single_sum", 32'(checksum), 32'h A5);

    // Burst 01..05
    clear();
    for (int i = 1; i <= 5; i++) send_word(8'(i));
    idle(3);
    drain();
    chk("burst_count", 32'(word_count), 5);
    chk("burst_sum", 32'(checksum), 32'h01);
    chk("burst_empty", 32'(m_if.m_valid), 0);

    // Backpressure: only two captures fit while m_ready is low
    clear();
    chk_gap  = 1'b0;
    rdy_mode = 0;
    idle(2);
    fork
      begin
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h33);
        send_word(8'h44);
      end
      begin
        idle(30);
        chk("bp_count", 32'(word_count), 2);
        chk("bp_done", 32'(rx_done), 0);
        chk("bp_valid", 32'(m_if.m_valid), 1);
        chk("bp_head", 32'(m_if.m_data), 32'h11);
        rdy_mode = 1;
      end
    join
    idle(3);
    drain();
    chk_stats("bp");

    // Counter wrap: 17 words into a 4-bit counter
    clear();
    chk_gap = 1'b1;
    for (int i = 0; i < 17; i++) send_word(8'($urandom));
    idle(3);
    drain();
    chk("wrap_count", 32'(word_count), 1);
    chk_stats("wrap");

    // Random traffic with random backpressure and enable
    chk_gap  = 1'b0;
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      send_word(8'($urandom));
      idle($urandom_range(0, 3));
    end
    rdy_mode = 1;
    idle(3);
    drain();
    chk_stats("rand");

    // clear_stats coincident with capture of 8'h3C
    idle(3);
    exp_q.push_back(8'h3C);
    rx_data     = 8'h3C;
    rx_rdy      = 1'b1;
    clear_stats = 1'b1;
    @(posedge clk);
    #1;
    clear_stats = 1'b0;
    mdl_cnt = 1;
    mdl_sum = 8'h3C;
    chk("clrcap_done", 32'(rx_done), 1);
    chk("clrcap_count", 32'(word_count), 1);
    chk("clrcap_sum", 32'(checksum), 32'h3C);
    rx_rdy = 1'b0;
    idle(4);
    drain();

    // Handshake timeout
    rdy_mode = 0;
    idle(2);
    exp_q.push_back(8'h77);
    mdl_cnt++;
    mdl_sum ^= 8'h77;
    rx_data = 8'h77;
    rx_rdy  = 1'b1;
    n = 0;
    while (rx_done !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("tmo_capture", 32'(rx_done), 1);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 15) chk("tmo_not_yet", 32'(proto_err), 0);
      if (i == 16) chk("tmo_set", 32'(proto_err), 1);
    end
    chk("tmo_stay_ack", 32'(rx_done), 1);
    rx_rdy = 1'b0;
    idle(5);
    chk("tmo_released", 32'(rx_done), 0);
    chk("tmo_sticky", 32'(proto_err), 1);
    chk_stats("tmo");
    clear();
    chk("tmo_cleared", 32'(proto_err), 0);
    chk("tmo_clr_count", 32'(word_count), 0);
    rdy_mode = 1;
    drain();

    // Reset while in ACK
    rdy_mode = 0;
    idle(3);
    exp_q.push_back(8'h5A);
    rx_data = 8'h5A;
    rx_rdy  = 1'b1;
    n = 0;
    while (rx_done !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rstack_capture", 32'(rx_done), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstack_done", 32'(rx_done), 0);
    chk("rstack_valid", 32'(m_if.m_valid), 0);
    chk("rstack_count", 32'(word_count), 0);
    exp_q.delete();
    mdl_cnt = 0;
    mdl_sum = '0;
    rx_data = 8'hC3;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(8'hC3);
    mdl_cnt = 1;
    mdl_sum = 8'hC3;
    done_rises = 0;
    n = 0;
    while (rx_done !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("resume_latency", n, 1);
    rx_rdy = 1'b0;
    idle(5);
    chk("resume_pulses", done_rises, 1);
    chk_stats("resume");
    rdy_mode = 1;
    drain();

    idle(5);
    chk("final_queue", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
